// File: rtl/mac_tile_dual.sv
// mac_tile_dual: one processing element of a systolic array that can run either
// weight-stationary (WS) or output-stationary (OS) dataflow, selected at runtime.
// Activations and instructions move west->east, psums/weights move north->south.
// Every output is registered, so each input reaches its output one cycle later.
module mac_tile_dual #(
    parameter int bw      = 4,   // activation (unsigned) / weight (signed) width
    parameter int psum_bw = 16,  // signed partial-sum / accumulator width
    parameter bit SAT     = 1'b0 // 0: wrap modulo 2^psum_bw, 1: clamp to signed range
) (
    input  logic               clk,
    input  logic               reset,   // asynchronous, active-low
    input  logic               mode,    // 0 = WS, 1 = OS
    input  logic [bw-1:0]      in_w,
    output logic [bw-1:0]      out_e,
    input  logic [2:0]         inst_w,  // [0] load, [1] execute, [2] flush/reload
    output logic [2:0]         inst_e,
    input  logic [psum_bw-1:0] in_n,
    output logic [psum_bw-1:0] out_s
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,   // WS, no weight latched yet
        WS_RDY = 2'd1,   // WS, stationary weight held in b_q
        OS_RUN = 2'd2    // OS, accumulating into acc_q
    } state_t;

    state_t             state_q, state_d;
    logic               mode_q;
    logic [bw-1:0]      b_q, b_d;          // stationary weight (WS)
    logic [bw-1:0]      a_q, a_d;          // activation forwarded east
    logic [psum_bw-1:0] acc_q, acc_d;      // stationary accumulator (OS)
    logic [psum_bw-1:0] out_s_q, out_s_d;
    logic [2:0]         inst_e_q, inst_e_d;

    // base + (unsigned a) * (signed b), evaluated one bit wider than the psum so
    // overflow is visible, then wrapped or clamped depending on SAT.
    // Operands are explicitly zero/sign-extended to psum_bw+1 bits; the low
    // psum_bw+1 bits of the modular product are then the exact signed product.
    function automatic logic [psum_bw-1:0] mac_fn(
        input logic [psum_bw-1:0] base,
        input logic [bw-1:0]      a,
        input logic [bw-1:0]      b
    );
        logic [psum_bw:0] a_x;
        logic [psum_bw:0] b_x;
        logic [psum_bw:0] prod_x;
        logic [psum_bw:0] sum_x;
        logic [psum_bw-1:0] res;
        a_x    = {{(psum_bw + 1 - bw){1'b0}}, a};
        b_x    = {{(psum_bw + 1 - bw){b[bw-1]}}, b};
        prod_x = a_x * b_x;
        sum_x  = {base[psum_bw-1], base} + prod_x;
        res    = sum_x[psum_bw-1:0];
        // Top two bits disagree -> result left the psum_bw signed range.
        if (SAT && (sum_x[psum_bw] != sum_x[psum_bw-1])) begin
            if (sum_x[psum_bw]) begin
                res = {1'b1, {(psum_bw - 1){1'b0}}};
            end else begin
                res = {1'b0, {(psum_bw - 1){1'b1}}};
            end
        end
        return res;
    endfunction

    // State and datapath registers; cleared immediately when reset drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= EMPTY;
            mode_q   <= 1'b0;
            b_q      <= '0;
            a_q      <= '0;
            acc_q    <= '0;
            out_s_q  <= '0;
            inst_e_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode;
            b_q      <= b_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            out_s_q  <= out_s_d;
            inst_e_q <= inst_e_d;
        end
    end

    // Next-state and next-output decode for both dataflows.
    always_comb begin
        state_d  = state_q;
        b_d      = b_q;
        a_d      = a_q;
        acc_d    = acc_q;
        out_s_d  = out_s_q;
        inst_e_d = inst_e_q;

        if (mode != mode_q) begin
            // Dataflow switch: the cycle's instruction is dropped so that a
            // half-issued operation never leaks into the new mode. The
            // activation register is left alone since no load/exec took place.
            state_d  = mode ? OS_RUN : EMPTY;
            acc_d    = '0;
            inst_e_d = '0;
            out_s_d  = '0;
        end else begin
            if (inst_w[0] | inst_w[1]) begin
                a_d = in_w;
            end
            // Execute and flush always travel east; the load bit is only
            // forwarded once this tile already owns a weight.
            inst_e_d = {inst_w[2], inst_w[1], 1'b0};

            case (state_q)
                EMPTY: begin
                    // No weight yet: psums pass straight through.
                    out_s_d = in_n;
                    if (inst_w[2]) begin
                        b_d = '0;
                    end else if (inst_w[0]) begin
                        // First load pulse is consumed here, not forwarded.
                        b_d     = in_w;
                        state_d = WS_RDY;
                    end
                end
                WS_RDY: begin
                    inst_e_d[0] = inst_w[0];
                    out_s_d     = in_n;
                    if (inst_w[2]) begin
                        // Reload request: drop the weight and wait for a new load.
                        b_d     = '0;
                        state_d = EMPTY;
                    end else if (inst_w[1]) begin
                        out_s_d = mac_fn(in_n, in_w, b_q);
                    end
                end
                OS_RUN: begin
                    if (inst_w[2]) begin
                        // Column drain: emit our sum, take the one from above.
                        out_s_d = acc_q;
                        acc_d   = in_n;
                    end else if (inst_w[1]) begin
                        // Weight arrives from north in the low bits and is
                        // passed on south for the next row.
                        acc_d   = mac_fn(acc_q, in_w, in_n[bw-1:0]);
                        out_s_d = {{(psum_bw - bw){1'b0}}, in_n[bw-1:0]};
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    assign out_e  = a_q;
    assign inst_e = inst_e_q;
    assign out_s  = out_s_q;

endmodule

// File: tb/tb_mac_tile_dual.sv
// Bench for mac_tile_dual: two tiles (16-bit wrapping, 8-bit saturating) share one
// stimulus stream. A driver updates an integer reference model and queues the
// expected outputs; a monitor pops one entry after each clock edge and compares.
module tb_mac_tile_dual;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        mode   = 1'b0;
    logic [3:0]  in_w   = '0;
    logic [2:0]  inst_w = '0;
    logic [15:0] in_n   = '0;

    logic [3:0]  out_e_a, out_e_b;
    logic [2:0]  inst_e_a, inst_e_b;
    logic [15:0] out_s_a;
    logic [7:0]  out_s_b;

    always #5 clk = ~clk;

    mac_tile_dual #(.bw(4), .psum_bw(16), .SAT(1'b0)) dut_a (
        .clk(clk), .reset(reset), .mode(mode),
        .in_w(in_w), .out_e(out_e_a),
        .inst_w(inst_w), .inst_e(inst_e_a),
        .in_n(in_n), .out_s(out_s_a)
    );

    mac_tile_dual #(.bw(4), .psum_bw(8), .SAT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .mode(mode),
        .in_w(in_w), .out_e(out_e_b),
        .inst_w(inst_w), .inst_e(inst_e_b),
        .in_n(in_n[7:0]), .out_s(out_s_b)
    );

    // Reference model: plain integers, one record per tile.
    typedef struct {
        int mode_q;
        int has_w;
        int w;
        int acc;
        int out_s;
        int out_e;
        int inst_e;
    } mdl_t;

    typedef struct {
        int s_a;
        int s_b;
        int e_a;
        int e_b;
        int ie_a;
        int ie_b;
    } exp_t;

    exp_t q[$];
    mdl_t ma, mb;
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Interpret the low w bits of v as a two's complement number.
    function automatic int sx(input int v, input int w);
        int m;
        m = v & ((1 << w) - 1);
        return (m >= (1 << (w - 1))) ? m - (1 << w) : m;
    endfunction

    // Bring an exact sum back into a pw-bit signed result.
    function automatic int fit(input int s, input int pw, input bit sat);
        int lo, hi;
        lo = -(1 << (pw - 1));
        hi = (1 << (pw - 1)) - 1;
        if (sat) return (s < lo) ? lo : ((s > hi) ? hi : s);
        return sx(s, pw);
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m = '{0, 0, 0, 0, 0, 0, 0};
        return m;
    endfunction

    // One clock of tile behaviour for a tile with pw-bit psums.
    function automatic mdl_t step(input mdl_t m, input int pw, input bit sat,
                                  input int md, input int a, input int inst, input int n_raw);
        int n, wt, ie0;
        n  = sx(n_raw, pw);
        wt = sx(n_raw, 4);
        if (md != m.mode_q) begin
            m.mode_q = md;
            m.has_w  = 0;
            m.acc    = 0;
            m.inst_e = 0;
            m.out_s  = 0;
            return m;
        end
        if ((inst & 3) != 0) m.out_e = a;
        ie0 = 0;
        if (md == 0) begin
            if (m.has_w != 0) ie0 = inst & 1;
            m.out_s = n;
            if ((inst & 4) != 0) begin
                m.has_w = 0;
                m.w     = 0;
            end else if (m.has_w == 0) begin
                if ((inst & 1) != 0) begin
                    m.w     = sx(a, 4);
                    m.has_w = 1;
                end
            end else if ((inst & 2) != 0) begin
                m.out_s = fit(n + a * m.w, pw, sat);
            end
        end else begin
            if ((inst & 4) != 0) begin
                m.out_s = m.acc;
                m.acc   = n;
            end else if ((inst & 2) != 0) begin
                m.acc   = fit(m.acc + a * wt, pw, sat);
                m.out_s = n_raw & 15;
            end
        end
        m.inst_e = (inst & 6) | ie0;
        return m;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Apply one cycle of stimulus and queue what both tiles must show after the edge.
    task automatic drive(input int md, input int a, input int inst, input int n);
        exp_t e;
        @(negedge clk);
        mode   = md[0];
        in_w   = a[3:0];
        inst_w = inst[2:0];
        in_n   = n[15:0];
        ma = step(ma, 16, 1'b0, md & 1, a & 15, inst & 7, n & 16'hFFFF);
        mb = step(mb, 8, 1'b1, md & 1, a & 15, inst & 7, n & 8'hFF);
        e = '{ma.out_s, mb.out_s, ma.out_e, mb.out_e, ma.inst_e, mb.inst_e};
        q.push_back(e);
    endtask

    // Wait until the last driven cycle has been clocked in.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one queued expectation per clock edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                txn++;
                $display("txn %0d out_s_a=%0d out_s_b=%0d out_e=%0d inst_e=%0d", txn,
                         $signed(out_s_a), $signed(out_s_b), out_e_a, inst_e_a);
                chk("out_s_a",  int'($signed(out_s_a)), e.s_a);
                chk("out_s_b",  int'($signed(out_s_b)), e.s_b);
                chk("out_e_a",  int'(out_e_a),  e.e_a);
                chk("out_e_b",  int'(out_e_b),  e.e_b);
                chk("inst_e_a", int'(inst_e_a), e.ie_a);
                chk("inst_e_b", int'(inst_e_b), e.ie_b);
            end
        end
    end

    initial begin
        int cur_mode;
        ma = mdl_reset();
        mb = mdl_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_out_s_a",  int'(out_s_a), 0);
        chk("reset_out_s_b",  int'(out_s_b), 0);
        chk("reset_out_e_a",  int'(out_e_a), 0);
        chk("reset_inst_e_a", int'(inst_e_a), 0);
        @(negedge clk);
        reset = 1'b1;

        // WS load, then execute a=5 with weight -3 on psum 10.
        drive(0, 13, 1, 0);     settle(); chk("t1_load_inst_e", int'(inst_e_a), 0);
        drive(0, 5, 2, 10);     settle(); chk("t1_exec", int'($signed(out_s_a)), -5);

        // Second load forwarded east, weight unchanged; reload then new load.
        drive(0, 2, 1, 0);      settle(); chk("t2_fwd_load", int'(inst_e_a), 1);
        drive(0, 1, 2, 0);      settle(); chk("t2_weight_kept", int'($signed(out_s_a)), -3);
        drive(0, 0, 4, 0);      settle(); chk("t2_flush_inst_e", int'(inst_e_a), 4);
        drive(0, 2, 1, 0);      settle(); chk("t2_reload_consumed", int'(inst_e_a), 0);
        drive(0, 3, 2, 0);      settle(); chk("t2_new_weight", int'($signed(out_s_a)), 6);

        // Saturation on the 8-bit tile, wrapping on the 16-bit tile.
        drive(0, 0, 4, 0);
        drive(0, 7, 1, 0);
        drive(0, 15, 2, 125);   settle();
        chk("t4_sat_hi_b", int'($signed(out_s_b)), 127);
        chk("t4_nosat_a",  int'($signed(out_s_a)), 230);
        drive(0, 15, 2, 32767); settle();
        chk("t4_wrap_a",   int'($signed(out_s_a)), -32664);
        chk("t4_low8_b",   int'($signed(out_s_b)), 104);
        drive(0, 0, 4, 0);
        drive(0, 8, 1, 0);
        drive(0, 15, 2, -120);  settle();
        chk("t4_sat_lo_b", int'($signed(out_s_b)), -128);
        chk("t4_neg_a",    int'($signed(out_s_a)), -240);

        // OS accumulate 4 x (3*2) then drain.
        drive(1, 0, 0, 0);      settle(); chk("t3_mode_out_s", int'(out_s_a), 0);
        repeat (4) drive(1, 3, 2, 2);
        settle(); chk("t3_weight_fwd", int'(out_s_a), 2);
        drive(1, 0, 4, 7);      settle(); chk("t3_drain", int'($signed(out_s_a)), 24);
        drive(1, 0, 4, 0);      settle(); chk("t3_shift_in", int'($signed(out_s_a)), 7);

        // Mode toggle with a live accumulator.
        repeat (4) drive(1, 3, 2, 2);
        drive(0, 5, 2, 0);      settle();
        chk("t5_inst_e", int'(inst_e_a), 0);
        chk("t5_out_s",  int'(out_s_a), 0);
        drive(0, 5, 2, 9);      settle(); chk("t5_empty_pass", int'($signed(out_s_a)), 9);
        drive(1, 0, 0, 0);
        drive(1, 0, 4, 0);      settle(); chk("t5_acc_cleared", int'(out_s_a), 0);

        // Asynchronous reset between edges while a weight is loaded.
        drive(0, 0, 0, 0);
        drive(0, 3, 1, 0);
        drive(0, 2, 2, 50);     settle(); chk("t6_pre", int'($signed(out_s_a)), 56);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_out_s_a",  int'(out_s_a), 0);
        chk("t6_out_s_b",  int'(out_s_b), 0);
        chk("t6_out_e_a",  int'(out_e_a), 0);
        chk("t6_inst_e_a", int'(inst_e_a), 0);
        ma = mdl_reset();
        mb = mdl_reset();
        reset = 1'b1;
        drive(0, 4, 2, 33);     settle(); chk("t6_load_required", int'($signed(out_s_a)), 33);

        // Randomized traffic against the model.
        cur_mode = 0;
        for (int i = 0; i < 400; i++) begin
            int inst;
            if ($urandom_range(0, 24) == 0) cur_mode = 1 - cur_mode;
            inst = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 7));
            if ((inst & 4) != 0 && $urandom_range(0, 2) != 0) inst = inst & 3;
            drive(cur_mode, int'($urandom_range(0, 15)), inst, int'($urandom & 32'hFFFF));
        end

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
